// File: rtl/window_seq_ctrl.sv
// 3x3 line-buffer feed sequencer: streams one frame from the feature
// buffer and tags each cycle that holds a complete non-wrapping window.
module window_seq_ctrl #(
  parameter int W_L1   = 28,
  parameter int W_L2   = 12,
  parameter int AWIDTH = 10,
  parameter int RD_LAT = 1,
  parameter int CWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              layer_sel,
  input  logic [AWIDTH-1:0] base_addr,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  output logic              convlayer_state,
  output logic              win_valid,
  output logic [CWIDTH-1:0] win_row,
  output logic [CWIDTH-1:0] win_col,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CWIDTH-1:0] r_w;
  logic [CWIDTH-1:0] r_row;
  logic [CWIDTH-1:0] r_col;
  logic [CWIDTH-1:0] r_dcnt;
  logic [AWIDTH-1:0] r_addr;
  logic              r_layer;

  logic [RD_LAT:0]             r_tv;
  logic [RD_LAT:0][CWIDTH-1:0] r_tr;
  logic [RD_LAT:0][CWIDTH-1:0] r_tc;

  logic [CWIDTH-1:0] w_wm1;
  logic              w_accept;
  logic              w_feed;
  logic              w_col_last;
  logic              w_last;
  logic              w_drain_end;
  logic              w_tvalid;

  assign w_wm1       = r_w - CWIDTH'(1);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_col_last  = (r_col == w_wm1);
  assign w_last      = w_col_last && (r_row == w_wm1);
  assign w_drain_end = (r_dcnt == CWIDTH'(RD_LAT));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next = r_state;
    w_feed = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FEED;
      end
      S_FEED: begin
        w_feed = 1'b1;
        busy   = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_drain_end) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // Frame latches, raster counters, address and drain counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_layer <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_layer <= layer_sel;
        r_w     <= layer_sel ? CWIDTH'(W_L2) : CWIDTH'(W_L1);
        r_addr  <= base_addr;
        r_row   <= '0;
        r_col   <= '0;
      end else if (w_feed) begin
        r_addr <= r_addr + AWIDTH'(1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + CWIDTH'(1);
        end else begin
          r_col <= r_col + CWIDTH'(1);
        end
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + CWIDTH'(1);
      else                    r_dcnt <= '0;
    end
  end

  // Tag delay line: memory latency plus the line-buffer input register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tv <= '0;
      r_tr <= '0;
      r_tc <= '0;
    end else begin
      r_tv[0] <= w_feed;
      r_tr[0] <= r_row;
      r_tc[0] <= r_col;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tr[i] <= r_tr[i-1];
        r_tc[i] <= r_tc[i-1];
      end
    end
  end

  assign w_tvalid = r_tv[RD_LAT]
                 && (r_tr[RD_LAT] >= CWIDTH'(2))
                 && (r_tc[RD_LAT] >= CWIDTH'(2));

  assign rd_en           = w_feed;
  assign rd_addr         = r_addr;
  assign convlayer_state = r_layer;
  assign win_valid       = w_tvalid;
  assign win_row = w_tvalid ? r_tr[RD_LAT] - CWIDTH'(2) : '0;
  assign win_col = w_tvalid ? r_tc[RD_LAT] - CWIDTH'(2) : '0;

endmodule
